// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: pipeline control inputs, instruction-memory port and IF/ID outputs.
// The master side is the fetch unit itself; the slave side is the surrounding pipeline/memory.
interface fetch_unit_if;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectTarget;
    logic [31:0] ImemAddress;
    logic [31:0] ImemInstruction;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;
    logic [31:0] FetchCount;

    modport master (
        input  Stall,
        input  Redirect,
        input  RedirectTarget,
        input  ImemInstruction,
        output ImemAddress,
        output IFID_Instruction,
        output IFID_PCPlus4,
        output IFID_Valid,
        output FetchCount
    );

    modport slave (
        output Stall,
        output Redirect,
        output RedirectTarget,
        output ImemInstruction,
        input  ImemAddress,
        input  IFID_Instruction,
        input  IFID_PCPlus4,
        input  IFID_Valid,
        input  FetchCount
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a saturating fetch counter.
// Priority per edge is redirect, then stall, then normal advance; reset is asynchronous active-low.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_WORD = 32'h00000000
) (
    input  logic         Clk,
    input  logic         Reset,
    fetch_unit_if.master bus
);

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc_plus4;
    logic        r_valid;
    logic [31:0] r_fetch_count;

    wire  [31:0] w_pc_plus4;
    wire  [31:0] w_redirect_pc;
    wire  [31:0] w_count_inc;

    assign w_pc_plus4    = r_pc + 32'd4;
    // Low target bits are dropped so a misaligned target lands on its word.
    assign w_redirect_pc = {bus.RedirectTarget[31:2], 2'b00};
    assign w_count_inc   = (r_fetch_count == 32'hFFFFFFFF) ? r_fetch_count
                                                           : r_fetch_count + 32'd1;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_pc          <= RESET_PC;
            r_instr       <= NOP_WORD;
            r_pc_plus4    <= 32'd0;
            r_valid       <= 1'b0;
            r_fetch_count <= 32'd0;
        end else if (bus.Redirect) begin
            r_pc          <= w_redirect_pc;
            r_instr       <= NOP_WORD;
            r_pc_plus4    <= 32'd0;
            r_valid       <= 1'b0;
        end else if (!bus.Stall) begin
            r_pc          <= w_pc_plus4;
            r_instr       <= bus.ImemInstruction;
            r_pc_plus4    <= w_pc_plus4;
            r_valid       <= 1'b1;
            r_fetch_count <= w_count_inc;
        end
    end

    // PC goes straight to memory so the word for the current PC is ready before the edge.
    assign bus.ImemAddress      = r_pc;
    assign bus.IFID_Instruction = r_instr;
    assign bus.IFID_PCPlus4     = r_pc_plus4;
    assign bus.IFID_Valid       = r_valid;
    assign bus.FetchCount       = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a reference model pushes expected IF/ID state per step,
// which is popped and compared one time unit after the following rising edge.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h00000013;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC (32'h00000000),
        .NOP_WORD (NOP)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    // Instruction memory: word i holds i*3, indexed by address bits [8:2].
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {25'd0, addr[8:2]} * 32'd3;
    endfunction

    assign bus.ImemInstruction = mem_word(bus.ImemAddress);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] p4;
        logic        v;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc, m_ins, m_p4, m_cnt;
    logic        m_v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc  = 32'h00000000;
        m_ins = NOP;
        m_p4  = 32'd0;
        m_v   = 1'b0;
        m_cnt = 32'd0;
    endtask

    task automatic check_state(input string tag, input exp_t e);
        chk({tag, ".pc"},    bus.ImemAddress,       e.pc);
        chk({tag, ".ins"},   bus.IFID_Instruction,  e.ins);
        chk({tag, ".p4"},    bus.IFID_PCPlus4,      e.p4);
        chk({tag, ".valid"}, {31'd0, bus.IFID_Valid}, {31'd0, e.v});
        chk({tag, ".cnt"},   bus.FetchCount,        e.cnt);
    endtask

    // Drive one cycle of control at the falling edge, predict, then compare after the rising edge.
    task automatic step(input logic st, input logic rd, input logic [31:0] tgt, input string tag);
        exp_t e;
        bus.Stall          = st;
        bus.Redirect       = rd;
        bus.RedirectTarget = tgt;
        if (rd) begin
            m_pc  = {tgt[31:2], 2'b00};
            m_ins = NOP;
            m_p4  = 32'd0;
            m_v   = 1'b0;
        end else if (!st) begin
            m_ins = mem_word(m_pc);
            m_p4  = m_pc + 32'd4;
            m_pc  = m_pc + 32'd4;
            m_v   = 1'b1;
            if (m_cnt != 32'hFFFFFFFF) m_cnt = m_cnt + 32'd1;
        end
        e.pc = m_pc; e.ins = m_ins; e.p4 = m_p4; e.v = m_v; e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        check_state(tag, e);
        $display("step %-12s stall=%0b redir=%0b tgt=%h -> pc=%h ins=%h p4=%h v=%0b cnt=%h",
                 tag, st, rd, tgt, bus.ImemAddress, bus.IFID_Instruction,
                 bus.IFID_PCPlus4, bus.IFID_Valid, bus.FetchCount);
        @(negedge Clk);
    endtask

    initial begin
        exp_t r;
        bus.Stall          = 1'b0;
        bus.Redirect       = 1'b0;
        bus.RedirectTarget = 32'd0;

        // Power-on reset, checked before any clock edge.
        #1 Reset = 1'b0;
        #1;
        model_reset();
        r.pc = m_pc; r.ins = m_ins; r.p4 = m_p4; r.v = m_v; r.cnt = m_cnt;
        check_state("reset", r);
        $display("reset asserted -> pc=%h ins=%h v=%0b", bus.ImemAddress, bus.IFID_Instruction, bus.IFID_Valid);
        @(negedge Clk);
        Reset = 1'b1;

        // Straight-line fetch from RESET_PC.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0, "straight");

        // Return to PC=8, then hold for three cycles and release.
        step(1'b0, 1'b1, 32'h00000000, "redir0");
        step(1'b0, 1'b0, 32'd0, "adv");
        step(1'b0, 1'b0, 32'd0, "adv");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, "stall");
        step(1'b0, 1'b0, 32'd0, "release");

        // Redirect wins over a simultaneous stall; misaligned target is word-aligned.
        step(1'b1, 1'b1, 32'h00000023, "redir_stall");
        step(1'b0, 1'b0, 32'd0, "after_redir");

        // Top-of-address-space wrap.
        step(1'b0, 1'b1, 32'hFFFFFFFF, "redir_top");
        step(1'b0, 1'b0, 32'd0, "wrap");

        // Reach PC=0x40 with a valid IF/ID, then reset between edges mid stall+redirect.
        step(1'b0, 1'b1, 32'h0000003C, "redir_3c");
        step(1'b0, 1'b0, 32'd0, "adv_40");
        #2;
        bus.Stall          = 1'b1;
        bus.Redirect       = 1'b1;
        bus.RedirectTarget = 32'h00000100;
        Reset              = 1'b0;
        #1;
        model_reset();
        r.pc = m_pc; r.ins = m_ins; r.p4 = m_p4; r.v = m_v; r.cnt = m_cnt;
        check_state("async_rst", r);
        $display("async reset mid-cycle -> pc=%h ins=%h v=%0b cnt=%h",
                 bus.ImemAddress, bus.IFID_Instruction, bus.IFID_Valid, bus.FetchCount);
        @(posedge Clk);
        #1;
        check_state("rst_hold", r);
        @(negedge Clk);
        Reset = 1'b1;
        step(1'b0, 1'b0, 32'd0, "restart");
        step(1'b0, 1'b0, 32'd0, "restart");

        // Saturation: preload the counter increment path to just below the limit.
        m_cnt = 32'hFFFFFFFD;
        force dut.w_count_inc = 32'hFFFFFFFE;
        step(1'b0, 1'b0, 32'd0, "sat_preload");
        release dut.w_count_inc;
        step(1'b0, 1'b0, 32'd0, "sat_max");
        step(1'b0, 1'b0, 32'd0, "sat_hold");
        step(1'b1, 1'b0, 32'd0, "sat_stall");
        step(1'b0, 1'b0, 32'd0, "sat_hold2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000: PC value loaded while Reset is asserted.
REQ-002 Parameter NOP_WORD, default 32'h00000000: instruction word inserted into IF/ID on flush or reset.
REQ-003 The module SHALL have port Clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 The module SHALL have port Reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-005 The module SHALL have port Stall, input, 1 bit: hazard stall; holds PC and IF/ID.
REQ-006 The module SHALL have port Redirect, input, 1 bit: taken branch or jump; reload PC and flush IF/ID.
REQ-007 The module SHALL have port RedirectTarget, input, 32 bits: byte address of the branch or jump target.
REQ-008 The module SHALL have port ImemAddress, output, 32 bits: current PC, driven to instruction memory (memory indexes bits [8:2]).
REQ-009 The module SHALL have port ImemInstruction, input, 32 bits: combinational instruction returned for ImemAddress.
REQ-010 The module SHALL have port IFID_Instruction, output, 32 bits: registered fetched instruction.
REQ-011 The module SHALL have port IFID_PCPlus4, output, 32 bits: registered PC+4 of that instruction.
REQ-012 The module SHALL have port IFID_Valid, output, 1 bit: IF/ID holds a real fetched instruction.
REQ-013 The module SHALL have port FetchCount, output, 32 bits: count of instructions latched with valid=1.

Function
REQ-014 ImemAddress SHALL equal the PC register combinationally, with no extra cycle of latency.
REQ-015 Per rising edge, priority SHALL be Redirect > Stall > normal advance.
REQ-016 On normal advance (Redirect=0, Stall=0), the block SHALL set PC <= PC+4, IFID_Instruction <= ImemInstruction, IFID_PCPlus4 <= PC+4, IFID_Valid <= 1, and FetchCount <= FetchCount+1.
REQ-017 On Stall=1 with Redirect=0, the PC, all IF/ID outputs and FetchCount SHALL hold their values.
REQ-018 On Redirect=1, regardless of Stall, the block SHALL set PC <= {RedirectTarget[31:2],2'b00}, IFID_Instruction <= NOP_WORD, IFID_PCPlus4 <= 0, IFID_Valid <= 0, and hold FetchCount.
REQ-019 RedirectTarget[1:0] SHALL be ignored; a misaligned target is silently word-aligned.
REQ-020 PC arithmetic SHALL be modulo 2^32: PC 32'hFFFFFFFC advances to 32'h00000000, and IFID_PCPlus4 = 32'h00000000.
REQ-021 FetchCount SHALL saturate at 32'hFFFFFFFF and SHALL NOT wrap.
REQ-022 The instruction latched SHALL be the one addressed by the pre-edge PC, giving one-cycle fetch-to-IF/ID latency.
REQ-023 ImemInstruction SHALL be sampled only on normal advance and SHALL be ignored on stall or redirect cycles.

Reset
REQ-024 While Reset=0, the block SHALL immediately, without waiting for Clk, set PC = RESET_PC, IFID_Instruction = NOP_WORD, IFID_PCPlus4 = 0, IFID_Valid = 0, and FetchCount = 0.
REQ-025 Reset asserted mid-stall or mid-redirect SHALL override both, with no residual state retained.
REQ-026 On the first rising edge after Reset deasserts, with Stall=0 and Redirect=0, the block SHALL latch the word at RESET_PC.

Verification
REQ-027 Straight-line fetch: reset, then 4 free-running cycles with memory[i]=i*3 -> IFID_Instruction 0,3,6,9; IFID_PCPlus4 4,8,12,16; FetchCount=4; ImemAddress=16.
REQ-028 Stall: at PC=8, Stall=1 for 3 cycles -> ImemAddress stays 8, IF/ID unchanged, FetchCount unchanged; on release the next edge latches memory[2].
REQ-029 Redirect with simultaneous Stall: Redirect=1, Stall=1, RedirectTarget=32'h00000023 -> PC=32'h20, IFID_Valid=0, IFID_Instruction=NOP_WORD; the next free cycle latches memory[8] with IFID_PCPlus4=32'h24.
REQ-030 Wrap: force a redirect to 32'hFFFFFFFC, then 1 free cycle -> PC=0, IFID_PCPlus4=0, IFID_Valid=1.
REQ-031 Async reset: assert Reset=0 between clock edges while PC=32'h40 and IFID_Valid=1 -> outputs reach reset values before the next edge; after release, fetch restarts at RESET_PC.
REQ-032 Saturation: preload FetchCount near the limit via a long run or a bench override, then advance -> the count holds at 32'hFFFFFFFF.
